// File: rtl/bpeb_weight_decoder.sv
// bpeb_weight_decoder
// Sequential decoder for BPEB-encoded weights. It rebuilds the signed weight
// from radix-4 Booth triplets one term per cycle. It also recounts the
// effective terms (ETC), so the count supplied with the weight can be checked.
// Optional build macro: BPEB_DEC_SKIP_ZERO_EN. When it is defined, DECODE
// jumps straight to the next effective, non-abandoned triplet. The decoded
// result is the same as in the default build; only the cycle count changes.
module bpeb_weight_decoder #(
  parameter int weight_width     = 16,
  parameter int num_groups       = (weight_width + 1) / 2,
  parameter int weight_bpr_width = num_groups * 3,
  parameter int ETC_width        = 4,
  parameter int acc_width        = weight_width + 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [weight_bpr_width-1:0] in_bpr,
  input  logic [ETC_width-1:0]        in_etc,
  input  logic [3:0]                  in_n_ap,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [acc_width-1:0]        out_value,
  output logic [ETC_width-1:0]        out_etc,
  output logic                        out_etc_err,
  output logic                        busy
);

  localparam int IDX_W = (num_groups > 1) ? $clog2(num_groups) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                      state_r, state_nxt_s;
  logic [weight_bpr_width-1:0] bpr_r;
  logic [ETC_width-1:0]        etc_r;
  logic [3:0]                  n_ap_r;
  logic [acc_width-1:0]        acc_r, acc_nxt_s;
  logic [ETC_width-1:0]        cnt_r, cnt_nxt_s;
  logic [IDX_W-1:0]            idx_r, idx_nxt_s;
  logic                        in_ready_r, busy_r;
  logic                        out_valid_r, out_etc_err_r;
  logic [acc_width-1:0]        out_value_r;
  logic [ETC_width-1:0]        out_etc_r;

  logic [IDX_W-1:0]            proc_idx_s;
  logic                        proc_en_s;
  logic                        proc_last_s;
  logic [2:0]                  trip_s;
  logic                        trip_eff_s;
  logic [2:0]                  digit_s;
  logic [acc_width-1:0]        term_s;
  logic                        accept_s;

  // Booth digit -2*b2 + b1 + b0 as a 3-bit two's-complement value
  function automatic logic [2:0] booth_digit(input logic [2:0] t);
    logic [2:0] d;
    case (t)
      3'b000:  d = 3'b000;
      3'b001:  d = 3'b001;
      3'b010:  d = 3'b001;
      3'b011:  d = 3'b010;
      3'b100:  d = 3'b110;
      3'b101:  d = 3'b111;
      3'b110:  d = 3'b111;
      3'b111:  d = 3'b000;
      default: d = 3'b000;
    endcase
    return d;
  endfunction

  assign accept_s = in_valid && in_ready_r;

`ifdef BPEB_DEC_SKIP_ZERO_EN
  logic [num_groups-1:0] eff_s;
  logic                  more_s;

  // Priority-encode the lowest effective, kept triplet at or above idx
  always_comb begin
    eff_s      = '0;
    proc_idx_s = idx_r;
    proc_en_s  = 1'b0;
    more_s     = 1'b0;
    for (int g = 0; g < num_groups; g++) begin
      eff_s[g] = (bpr_r[3*g +: 3] != 3'b000) && (bpr_r[3*g +: 3] != 3'b111) &&
                 (g >= int'(n_ap_r));
    end
    for (int g = num_groups - 1; g >= 0; g--) begin
      if (eff_s[g] && (g >= int'(idx_r))) begin
        proc_idx_s = IDX_W'(g);
        proc_en_s  = 1'b1;
      end else begin
        proc_en_s  = proc_en_s;
      end
    end
    for (int g = 0; g < num_groups; g++) begin
      if (proc_en_s && eff_s[g] && (g > int'(proc_idx_s))) begin
        more_s = 1'b1;
      end else begin
        more_s = more_s;
      end
    end
    proc_last_s = !more_s;
  end
`else
  // Walk every triplet in order; abandoned low groups are masked to zero
  always_comb begin
    proc_idx_s  = idx_r;
    proc_en_s   = int'(idx_r) >= int'(n_ap_r);
    proc_last_s = int'(idx_r) == (num_groups - 1);
  end
`endif

  // Current triplet, its digit and its weighted contribution
  always_comb begin
    trip_s     = proc_en_s ? bpr_r[3*int'(proc_idx_s) +: 3] : 3'b000;
    trip_eff_s = (trip_s != 3'b000) && (trip_s != 3'b111);
    digit_s    = booth_digit(trip_s);
    term_s     = {{(acc_width-3){digit_s[2]}}, digit_s} << {proc_idx_s, 1'b0};
  end

  // Next-state and accumulator update
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = DECODE;
          acc_nxt_s   = '0;
          cnt_nxt_s   = '0;
          idx_nxt_s   = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DECODE: begin
        acc_nxt_s = acc_r + term_s;
        if (trip_eff_s) begin
          cnt_nxt_s = cnt_r + ETC_width'(1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
        if (proc_last_s) begin
          state_nxt_s = DONE;
        end else begin
          idx_nxt_s = proc_idx_s + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_valid_r && out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register plus registered ready/busy flags derived from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s == IDLE);
      busy_r     <= (state_nxt_s != IDLE);
    end
  end

  // Decode datapath registers and capture of the accepted weight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r  <= '0;
      cnt_r  <= '0;
      idx_r  <= '0;
      bpr_r  <= '0;
      etc_r  <= '0;
      n_ap_r <= 4'd0;
    end else begin
      acc_r <= acc_nxt_s;
      cnt_r <= cnt_nxt_s;
      idx_r <= idx_nxt_s;
      if (accept_s) begin
        bpr_r  <= in_bpr;
        etc_r  <= in_etc;
        n_ap_r <= in_n_ap;
      end
    end
  end

  // Result registers: loaded on the first DONE cycle, held until handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r   <= 1'b0;
      out_value_r   <= '0;
      out_etc_r     <= '0;
      out_etc_err_r <= 1'b0;
    end else if ((state_r == DONE) && !out_valid_r) begin
      out_valid_r   <= 1'b1;
      out_value_r   <= acc_r;
      out_etc_r     <= cnt_r;
      out_etc_err_r <= (cnt_r != etc_r);
    end else if ((state_r == DONE) && out_ready) begin
      out_valid_r   <= 1'b0;
    end
  end

  assign in_ready    = in_ready_r;
  assign busy        = busy_r;
  assign out_valid   = out_valid_r;
  assign out_value   = out_value_r;
  assign out_etc     = out_etc_r;
  assign out_etc_err = out_etc_err_r;

endmodule

// File: tb/tb_bpeb_weight_decoder.sv
// Directed, table-driven bench for bpeb_weight_decoder, with hand sequences
// for backpressure and reset in the middle of a decode.
module tb_bpeb_weight_decoder;

  localparam int NG = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_bpr = 24'h0;
  logic [3:0]  in_etc = 4'd0;
  logic [3:0]  in_n_ap = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [17:0] out_value;
  logic [3:0]  out_etc;
  logic        out_etc_err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  bpeb_weight_decoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_bpr(in_bpr), .in_etc(in_etc), .in_n_ap(in_n_ap),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_etc(out_etc), .out_etc_err(out_etc_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] bpr;
    logic [3:0]  etc;
    logic [3:0]  nap;
    logic [17:0] val;
    logic [3:0]  exp_etc;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input logic [3:0] etc);
`ifdef BPEB_DEC_SKIP_ZERO_EN
    return ((etc == 4'd0) ? 1 : int'(etc)) + 1;
`else
    return NG + 1;
`endif
  endfunction

  // Present one weight and return the number of edges until out_valid
  task automatic send(input logic [23:0] bpr, input logic [3:0] etc, input logic [3:0] nap,
                      output int lat);
    int n;
    @(negedge clk);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_bpr = bpr; in_etc = etc; in_n_ap = nap;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_bpr = 24'hA5A5A5; in_etc = 4'hF; in_n_ap = 4'd0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = n;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("valid_drop", {31'd0, out_valid}, 32'd0);
    chk("ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{24'h00000E, 4'd2, 4'd0, 18'd3,     4'd2, 1'b0};
    vecs[1]  = '{24'hFFFFFE, 4'd1, 4'd0, 18'h3FFFF, 4'd1, 1'b0};
    vecs[2]  = '{24'h000009, 4'd1, 4'd1, 18'd4,     4'd1, 1'b0};
    vecs[3]  = '{24'h000000, 4'd0, 4'd0, 18'd0,     4'd0, 1'b0};
    vecs[4]  = '{24'h123456, 4'd0, 4'd8, 18'd0,     4'd0, 1'b0};
    vecs[5]  = '{24'h249249, 4'd3, 4'd15, 18'd0,    4'd0, 1'b1};
    vecs[6]  = '{24'h7FFFFE, 4'd2, 4'd0, 18'd32767, 4'd2, 1'b0};
    vecs[7]  = '{24'h800000, 4'd1, 4'd0, 18'h38000, 4'd1, 1'b0};
    vecs[8]  = '{24'h6C0000, 4'd2, 4'd0, 18'h0A000, 4'd2, 1'b0};
    vecs[9]  = '{24'h000249, 4'd4, 4'd3, 18'd64,    4'd1, 1'b1};
    vecs[10] = '{24'hFFFFEE, 4'd2, 4'd0, 18'h3FFFB, 4'd2, 1'b0};
    vecs[11] = '{24'h249249, 4'd8, 4'd0, 18'd21845, 4'd8, 1'b0};

    // reset state
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_value", {14'd0, out_value}, 32'd0);
    chk("rst_etc", {28'd0, out_etc}, 32'd0);
    chk("rst_err", {31'd0, out_etc_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].bpr, vecs[i].etc, vecs[i].nap, lat);
      chk($sformatf("latency[%0d]", i), lat, exp_latency(vecs[i].exp_etc));
      chk($sformatf("value[%0d]", i), {14'd0, out_value}, {14'd0, vecs[i].val});
      chk($sformatf("etc[%0d]", i), {28'd0, out_etc}, {28'd0, vecs[i].exp_etc});
      chk($sformatf("err[%0d]", i), {31'd0, out_etc_err}, {31'd0, vecs[i].err});
      handshake();
    end

    // ETC mismatch with 5 cycles of backpressure; in_* must be ignored meanwhile
    send(24'h00000E, 4'd3, 4'd0, lat);
    chk("bp_latency", lat, exp_latency(4'd2));
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_bpr = 24'hFFFFFF; in_etc = 4'd7;
      @(posedge clk);
      #1;
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_value", {14'd0, out_value}, 32'd3);
      chk("bp_etc", {28'd0, out_etc}, 32'd2);
      chk("bp_err", {31'd0, out_etc_err}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    handshake();

    // reset in the middle of a decode (all eight triplets effective)
    send(24'h249249, 4'd8, 4'd0, lat);
    handshake();
    @(negedge clk);
    in_valid = 1'b1; in_bpr = 24'h249249; in_etc = 4'd8; in_n_ap = 4'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_value", {14'd0, out_value}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(24'h00000E, 4'd2, 4'd0, lat);
    chk("post_rst_latency", lat, exp_latency(4'd2));
    chk("post_rst_value", {14'd0, out_value}, 32'd3);
    chk("post_rst_etc", {28'd0, out_etc}, 32'd2);
    chk("post_rst_err", {31'd0, out_etc_err}, 32'd0);
    handshake();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
